// File: rtl/lab5_fetch_if.sv
// -----------------------------------------------------------------------------
// lab5_fetch_if
//
// Purpose : groups the fetch stage's memory bus, the downstream control inputs
//           and the decode-facing outputs into one bundle.
//
// Signals :
//   addr       8  byte address to instruction memory (bit 0 always 0)
//   instr_in  16  instruction word returned by memory (combinational on addr)
//   stall      1  downstream hold request
//   br_taken   1  redirect request for the instruction currently in ir
//   br_target  8  byte address of the redirect
//   resume     1  level input (push-button) that restarts after HALT
//   ir        16  registered instruction for decode
//   valid      1  ir holds an instruction to execute this cycle
//   halted     1  high while parked on HALT
//
// Modports: master = fetch stage, slave = memory / downstream / environment.
// -----------------------------------------------------------------------------
interface lab5_fetch_if;
    logic [7:0]  addr;
    logic [15:0] instr_in;
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        resume;
    logic [15:0] ir;
    logic        valid;
    logic        halted;

    modport master (
        output addr, ir, valid, halted,
        input  instr_in, stall, br_taken, br_target, resume
    );

    modport slave (
        input  addr, ir, valid, halted,
        output instr_in, stall, br_taken, br_target, resume
    );
endinterface

// File: rtl/lab5_fetch.sv
// -----------------------------------------------------------------------------
// lab5_fetch
//
// Purpose : instruction fetch stage in front of a 128x16 instruction memory.
//           Owns the byte-addressed PC, captures the returned word into IR with
//           a valid flag, parks on HALT and restarts on a RESUME rising edge,
//           and accepts branch redirects and stalls from downstream.
//
// Ports   :
//   CLK      in   system clock, all state updates on the rising edge
//   RESET    in   synchronous, active-high reset
//   bus      --   lab5_fetch_if.master (memory bus, control inputs, IR/VALID)
//   icount   out  16-bit count of instructions delivered to decode
//                 (present only when LAB5_FETCH_ICOUNT_EN is defined)
//
// Parameters:
//   RESET_PC   byte address loaded into PC on reset (bit 0 forced to 0)
//   HALT_WORD  instruction encoding recognised as HALT
//
// Configuration macro: LAB5_FETCH_ICOUNT_EN adds the icount port and counter.
// -----------------------------------------------------------------------------
module lab5_fetch #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [15:0] HALT_WORD = 16'h0001
) (
    input  logic         CLK,
    input  logic         RESET,
    lab5_fetch_if.master bus
`ifdef LAB5_FETCH_ICOUNT_EN
   ,output logic [15:0]  icount
`endif
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        valid_q, valid_d;
    logic        resume_q;      // previous RESUME sample, for edge detection
    logic        resume_rise;
    logic        fetch_ok;      // a word is handed to decode on this edge

    assign resume_rise = bus.resume & ~resume_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_RUN;
            pc_q     <= {RESET_PC[7:1], 1'b0};
            ir_q     <= 16'h0000;
            valid_q  <= 1'b0;
            // Starts high so a button held through reset is not seen as a press.
            resume_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            resume_q <= bus.resume;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a hold/default value first, so no
    // path through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        fetch_ok = 1'b0;

        case (state_q)
            S_RUN: begin
                if (bus.br_taken) begin
                    // Redirect wins over stall and HALT; the word at the old PC
                    // is squashed and IR keeps its previous contents.
                    pc_d    = bus.br_target & 8'hFE;
                    valid_d = 1'b0;
                end else if (bus.stall) begin
                    // Hold everything.
                end else if (bus.instr_in == HALT_WORD) begin
                    // HALT never reaches decode; PC parks on the following word.
                    pc_d    = pc_q + 8'd2;
                    valid_d = 1'b0;
                    state_d = S_HALT;
                end else begin
                    ir_d     = bus.instr_in;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 8'd2;
                    fetch_ok = 1'b1;
                end
            end

            S_HALT: begin
                // Branches and stalls are ignored while parked.
                valid_d = 1'b0;
                if (resume_rise) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign bus.addr   = pc_q;
    assign bus.ir     = ir_q;
    assign bus.valid  = valid_q;
    assign bus.halted = (state_q == S_HALT);

`ifdef LAB5_FETCH_ICOUNT_EN
    // Counts only words actually delivered to decode; wraps naturally.
    logic [15:0] icount_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            icount_q <= 16'h0000;
        end else if (fetch_ok) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign icount = icount_q;
`endif

endmodule
